snd_arb_rr: RTL
===============

Name: snd_arb_rr

Overview:
- Parametrised successor of the channel-to-GTP send arbiter.
- Polls NFIFO channel FIFOs round-robin, skipping masked and empty channels, and sends exactly one block of winlen+3 words from the granted channel.
- Inserts a comma between blocks and when idle.
- Trigger K-character always has absolute out-of-band priority; sits between channel FIFOs and the GTP transmitter.

Parameters:
- NFIFO, 17: number of channel FIFOs (2..32).
- DW, 16: data word width (GTP word).
- LENW, 9: width of winlen.
- CH_COMMA, 16'h00BC: idle/separator K28.5 word.
- CH_TRIG, 16'h801C: trigger K28.0 word.
- STALL_MAX, 255: watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- arb_want  out  NFIFO  one-hot read request to channel FIFOs; a FIFO pops when want&have.
- fifo_have  in  NFIFO  per-channel data valid.
- datain  in  NFIFO*DW  channel data; channel i at [DW*i +: DW].
- chan_mask  in  NFIFO  1 = channel enabled for arbitration.
- winlen  in  LENW  window length; block length = winlen+3.
- trig  in  1  trigger request; send CH_TRIG this cycle.
- dataout  out  DW  GTP data, registered.
- kchar  out  1  1 = dataout is a K-character.
- busy  out  1  a block is in progress (state DATA or GAP).
- err  out  1  one-cycle pulse on block abort (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - dataout=CH_COMMA, kchar=1, arb_want=0, busy=0, err=0.
  - ptr=0, state=IDLE, towrite=0, stall=0.
- Reset release: takes effect on the first clk edge with rst_n=1; a mid-block reset drops the block with no partial framing.
- State IDLE:
  - Priority search for the first i with chan_mask[i]&fifo_have[i], starting at ptr and wrapping NFIFO-1 to 0.
  - Found: sel=i, towrite=winlen+3 sampled now, width LENW+1 so no overflow at winlen=all-ones, go to DATA.
  - Not found: stay IDLE.
  - Output CH_COMMA, kchar=1.
- State DATA:
  - arb_want = onehot(sel) & ~trig (combinational from registered sel/state).
  - Accept cycle (want&have): dataout<=datain[sel] next edge, kchar<=0, towrite-1, stall cleared.
  - Latency: accept at cycle N, word on dataout at N+1.
  - have=0: CH_COMMA/kchar=1 sent, block held (stall), stall+1.
  - Accept with towrite==1 (last word): ptr<=(sel==NFIFO-1)?0:sel+1, go GAP.
- State GAP: one cycle, arb_want=0, CH_COMMA/kchar=1, then IDLE. Guarantees at least one comma between consecutive blocks.
- trig=1 in any state:
  - dataout<=CH_TRIG, kchar<=1.
  - arb_want forced 0, so no pop.
  - State, ptr, towrite and stall are frozen that cycle.
  - Back-to-back trig cycles emit back-to-back CH_TRIG.
- Changes to chan_mask or winlen during a block take effect at the next IDLE search only; the current block always completes.
- Fairness: after channel k is served, every other enabled, ready channel is served before k again.
- busy = (state!=IDLE).

Optional Feature:
- Macro SND_ARB_STALL_TIMEOUT_EN.
- Defined:
  - In DATA, a stall counter (8 bits, saturating) counts non-trig cycles with have=0.
  - When it reaches STALL_MAX, abort the block: err pulses 1 cycle, ptr advances past sel, go GAP.
  - Remaining words of that block stay in the FIFO.
- Undefined: DATA waits for data indefinitely; err tied 0; no stall counter synthesised.

Test Plan:
- Reset with fifo_have=0 -> dataout=00BC, kchar=1, arb_want=0 continuously; busy=0.
- NFIFO=17, winlen=5, chan_mask=all, fifo_have[3] and [9] held 1 -> 8 data words from ch3, 1 comma, 8 words from ch9, 1 comma, then ch3 again; kchar=0 only on data.
- Pulse trig for 2 cycles mid-block on ch3 (word 4) -> two 801C/kchar=1 words, arb_want=0 during them, block resumes at word 5 with no loss or duplication; total 8 data words.
- chan_mask[3]=0, fifo_have[3]=1 and [16]=1, ptr=16 -> ch16 served, wrap skips ch3, ch16 served again.
- winlen=9'h1FF -> block of exactly 514 words; counter does not wrap.
- SND_ARB_STALL_TIMEOUT_EN, STALL_MAX=255, fifo_have[sel] drops after 2 words -> 255 commas, err=1 for one cycle, GAP comma, arbitration moves to next channel; without macro -> commas indefinitely, err=0.

Source files
------------

// File: rtl/snd_arb_rr.sv
// snd_arb_rr: round-robin send arbiter between NFIFO channel FIFOs and a
// GTP transmitter. One block of winlen+3 words is sent per grant, with a
// comma between blocks and while idle. A trigger request pre-empts
// everything for the cycle it is asserted and emits CH_TRIG.
//
// Optional build macro: SND_ARB_STALL_TIMEOUT_EN
//   defined   - a stalled block is aborted after STALL_MAX data-less cycles
//               and err pulses for one cycle.
//   undefined - a stalled block waits indefinitely; err is tied low.
module snd_arb_rr #(
    parameter int              NFIFO     = 17,
    parameter int              DW        = 16,
    parameter int              LENW      = 9,
    parameter logic [DW-1:0]   CH_COMMA  = 16'h00BC,
    parameter logic [DW-1:0]   CH_TRIG   = 16'h801C,
    parameter int              STALL_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [NFIFO-1:0]      arb_want,
    input  logic [NFIFO-1:0]      fifo_have,
    input  logic [NFIFO*DW-1:0]   datain,
    input  logic [NFIFO-1:0]      chan_mask,
    input  logic [LENW-1:0]       winlen,
    input  logic                  trig,
    output logic [DW-1:0]         dataout,
    output logic                  kchar,
    output logic                  busy,
    output logic                  err
);

    localparam int              PW = $clog2(NFIFO);
    localparam logic [PW:0]     NF = (PW+1)'(NFIFO);
    localparam logic [PW-1:0]   LAST_CH = PW'(NFIFO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       sel;
    logic [LENW:0]       towrite;

    // Search helpers: eligible channels rotated so that ptr sits at bit 0.
    logic [NFIFO-1:0]    elig;
    logic [2*NFIFO-1:0]  elig_dbl;
    logic [NFIFO-1:0]    rot;
    logic                found;
    logic [PW-1:0]       off;
    logic [PW:0]         cand_sum;
    logic [PW-1:0]       cand;

    logic                have_sel;
    logic [DW-1:0]       data_sel;
    logic [PW-1:0]       next_ptr;
    logic                last_word;
    logic [NFIFO-1:0]    sel_onehot;

    assign elig     = chan_mask & fifo_have;
    assign elig_dbl = {elig, elig} >> ptr;
    assign rot      = elig_dbl[NFIFO-1:0];

    // Lowest set bit of the rotated vector is the first eligible channel at or after ptr.
    always_comb begin
        // NOTE: defaults first so every path assigns found/off and no latch is inferred.
        found = 1'b0;
        off   = '0;
        for (int k = NFIFO - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k[PW-1:0];
            end
        end
    end

    assign cand_sum   = {1'b0, ptr} + {1'b0, off};
    assign cand       = (cand_sum >= NF) ? PW'(cand_sum - NF) : cand_sum[PW-1:0];

    assign have_sel   = fifo_have[sel];
    assign data_sel   = datain[DW*int'(sel) +: DW];
    assign next_ptr   = (sel == LAST_CH) ? '0 : sel + 1'b1;
    assign last_word  = (towrite == (LENW+1)'(1));
    assign sel_onehot = {{(NFIFO-1){1'b0}}, 1'b1} << sel;

    // Read request is only raised while a block is open and no trigger pre-empts it.
    assign arb_want   = (state == DATA && !trig) ? sel_onehot : '0;
    assign busy       = (state != IDLE);

`ifdef SND_ARB_STALL_TIMEOUT_EN
    logic [7:0] stall;
    logic       stall_abort;
    logic       err_q;

    assign stall_abort = (state == DATA) && !trig && !have_sel &&
                         (stall == 8'(STALL_MAX - 1));
    assign err = err_q;

    // Saturating count of data-less cycles inside a block; pulses err on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= stall_abort;
            if (!trig) begin
                if (state == IDLE || (state == DATA && (have_sel || stall_abort))) begin
                    stall <= '0;
                end else if (state == DATA && stall != 8'hFF) begin
                    stall <= stall + 8'd1;
                end
            end
        end
    end
`else
    assign err = 1'b0;
    wire unused_stall_cfg = |STALL_MAX;
`endif

    // Arbitration FSM with registered GTP word; trig freezes all state for its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            towrite <= '0;
            dataout <= CH_COMMA;
            kchar   <= 1'b1;
        end else if (trig) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            dataout <= CH_TRIG;
            kchar   <= 1'b1;
        end else begin
            dataout <= CH_COMMA;
            kchar   <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        sel     <= cand;
                        towrite <= {1'b0, winlen} + (LENW+1)'(3);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (have_sel) begin
                        dataout <= data_sel;
                        kchar   <= 1'b0;
                        towrite <= towrite - 1'b1;
                        if (last_word) begin
                            ptr   <= next_ptr;
                            state <= GAP;
                        end
`ifdef SND_ARB_STALL_TIMEOUT_EN
                    end else if (stall_abort) begin
                        ptr   <= next_ptr;
                        state <= GAP;
`endif
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
